// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Holds the controller state encoding, the hardwired-zero register number and
// the default event-counter width.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk_i : clock
//   clr   : synchronous clear, dominates inc
//   inc   : add one unless already at all-ones
//   q     : count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - PC / IF/ID / ID/EX sequencing for load-use, redirect and memory stalls
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   idex_memread_i/rt_i   : load in EX and its destination register
//   ifid_rs_i/rt_i        : source registers of the instruction in ID
//   ifid_uses_rt_i        : ID instruction actually reads rt
//   branch_taken_i,jump_i : control-flow redirect resolved in ID
//   mem_req_i/ready_i     : data-memory access handshake from MEM
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o : pipeline controls
//   stall_cnt_o, flush_cnt_o : saturating event counters
//   mem_err_o             : sticky data-memory timeout
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam int              WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memstall, loaduse, redirect, freeze;
  logic              stall_inc, flush_inc;

  assign memstall = mem_req_i & ~mem_ready_i;
  assign loaduse  = idex_memread_i & (idex_rt_i != REG_ZERO) &
                    ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));
  assign redirect = branch_taken_i | jump_i;

  // In MEMWAIT the freeze is held by the missing ready alone; the MEM stage
  // is frozen so mem_req_i is not re-qualified here.
  assign freeze = (state == MEMWAIT) ? ~mem_ready_i : memstall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      // Held at zero in RUN so every entry into MEMWAIT starts from zero;
      // parks at the last value so a long wait cannot wrap.
      if (state == RUN) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LAST) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if ((state == MEMWAIT) && !mem_ready_i && (wait_cnt == WAIT_LAST)) begin
        mem_err_o <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (freeze) begin
      pipe_freeze_o = 1'b1;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      stall_inc     = 1'b1;
      state_nxt     = MEMWAIT;
    end else begin
      // Not frozen: either RUN, or MEMWAIT on its ready cycle, which is
      // handled exactly like RUN so a waiting hazard is serviced at once.
      state_nxt = RUN;
      if (loaduse) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
        stall_inc     = 1'b1;
      end else if (redirect) begin
        ifid_flush_o = 1'b1;
        flush_inc    = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (stall_inc),
    .q     (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (flush_inc),
    .q     (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       idex_memread_i;
  logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic       ifid_uses_rt_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;
  logic       mem_err_o;

  int total = 0;
  int bad   = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] O_RST    = 5'b00010;
  localparam logic [4:0] O_IDLE   = 5'b11000;
  localparam logic [4:0] O_BUBBLE = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11100;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  logic [4:0] outs;
  assign outs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .ifid_uses_rt_i (ifid_uses_rt_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .mem_err_o      (mem_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    idex_memread_i = 1'b0; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
    ifid_uses_rt_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    #2;
    chk("rst_outs", 32'(outs), 32'(O_RST));
    tick();
    chk("rst_stall", 32'(stall_cnt_o), 0);
    chk("rst_flush", 32'(flush_cnt_o), 0);
    chk("rst_err", 32'(mem_err_o), 0);
    rst_i = 1'b0;
    #1;
    chk("idle_outs", 32'(outs), 32'(O_IDLE));

    // load-use on rs
    idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
    #1 chk("lu_rs_outs", 32'(outs), 32'(O_BUBBLE));
    tick();
    chk("lu_rs_cnt", 32'(stall_cnt_o), 1);
    idex_memread_i = 1'b0;
    #1 chk("lu_after", 32'(outs), 32'(O_IDLE));
    // load into r0 never stalls
    idex_memread_i = 1'b1; idex_rt_i = 5'd0; ifid_rs_i = 5'd0;
    #1 chk("lu_r0_outs", 32'(outs), 32'(O_IDLE));
    tick();
    chk("lu_r0_cnt", 32'(stall_cnt_o), 1);
    // rt match only counts when ID reads rt
    idex_rt_i = 5'd9; ifid_rs_i = 5'd3; ifid_rt_i = 5'd9; ifid_uses_rt_i = 1'b0;
    #1 chk("lu_rt_unused", 32'(outs), 32'(O_IDLE));
    ifid_uses_rt_i = 1'b1;
    #1 chk("lu_rt_used", 32'(outs), 32'(O_BUBBLE));
    tick();
    chk("lu_rt_cnt", 32'(stall_cnt_o), 2);

    // load-use together with branch: bubble wins, branch serviced next cycle
    do_reset();
    idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rs_i = 5'd5; branch_taken_i = 1'b1;
    #1 chk("lub_outs", 32'(outs), 32'(O_BUBBLE));
    tick();
    chk("lub_flush_cnt", 32'(flush_cnt_o), 0);
    chk("lub_stall_cnt", 32'(stall_cnt_o), 1);
    idex_memread_i = 1'b0;
    #1 chk("br_outs", 32'(outs), 32'(O_FLUSH));
    tick();
    chk("br_flush_cnt", 32'(flush_cnt_o), 1);
    branch_taken_i = 1'b0;

    // three-cycle memory wait
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw_freeze%0d", i), 32'(outs), 32'(O_FREEZE));
      tick();
    end
    mem_ready_i = 1'b1;
    #1 chk("mw_ready_outs", 32'(outs), 32'(O_IDLE));
    tick();
    chk("mw_stall_cnt", 32'(stall_cnt_o), 3);
    chk("mw_err", 32'(mem_err_o), 0);
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chk("mw_back_run", 32'(outs), 32'(O_IDLE));
    // response in the request cycle: no freeze
    mem_req_i = 1'b1; mem_ready_i = 1'b1;
    #1 chk("mw_fast_outs", 32'(outs), 32'(O_IDLE));
    tick();
    chk("mw_fast_cnt", 32'(stall_cnt_o), 3);
    mem_req_i = 1'b0; mem_ready_i = 1'b0;

    // timeout with MEM_TIMEOUT=4
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    tick();                       // RUN -> MEMWAIT
    for (int i = 0; i < 3; i++) tick();
    chk("to_err_early", 32'(mem_err_o), 0);
    tick();                       // fourth MEMWAIT cycle
    chk("to_err_set", 32'(mem_err_o), 1);
    mem_ready_i = 1'b1;
    tick();
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
    tick();
    chk("to_err_sticky", 32'(mem_err_o), 1);

    // reset pulsed in the middle of MEMWAIT
    mem_req_i = 1'b1;
    tick();
    tick();
    #1 chk("rmw_frozen", 32'(outs), 32'(O_FREEZE));
    rst_i = 1'b1;
    #1 chk("rmw_forced", 32'(outs), 32'(O_RST));
    tick();
    rst_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
    #1 chk("rmw_run", 32'(outs), 32'(O_IDLE));
    chk("rmw_err", 32'(mem_err_o), 0);
    chk("rmw_stall", 32'(stall_cnt_o), 0);
    chk("rmw_flush", 32'(flush_cnt_o), 0);

    // flush counter saturation with CNT_W=4
    jump_i = 1'b1;
    #1 chk("sat_outs", 32'(outs), 32'(O_FLUSH));
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(flush_cnt_o), 14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_20", 32'(flush_cnt_o), 15);
    jump_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides whether the PC, the IF/ID register and the ID/EX register advance, hold, or take a bubble/flush. It covers three cases: load-use hazards, taken branches/jumps resolved in ID, and multi-cycle data-memory accesses. It sits beside the IF/ID and ID/EX pipeline registers, keeps per-cause event counters, and raises a sticky error when a memory access times out.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum MEMWAIT cycles before mem_err_o sets (≥2)
- CNT_W, 16: width of the event counters

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- idex_memread_i  in  1  the instruction in EX is a load
- idex_rt_i  in  5  destination register of that load
- ifid_rs_i  in  5  rs of the instruction in ID
- ifid_rt_i  in  5  rt of the instruction in ID
- ifid_uses_rt_i  in  1  the ID instruction reads rt
- branch_taken_i  in  1  branch resolved taken in ID
- jump_i  in  1  jump decoded in ID
- mem_req_i  in  1  MEM stage issues a data-memory access
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC register enable
- ifid_write_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  load a NOP into IF/ID
- idex_bubble_o  out  1  zero all ID/EX control inputs (RegWrite, MemWrite, MemRead, Branch, Jump)
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- stall_cnt_o  out  CNT_W  load-use bubbles plus freeze cycles, saturating
- flush_cnt_o  out  CNT_W  flush events, saturating
- mem_err_o  out  1  sticky memory timeout

## Operation
- FSM states: RUN, MEMWAIT. The enables are combinational from state and inputs. State, counters and error are registered.
- Hazard conditions:
  - memstall = mem_req_i & ~mem_ready_i
  - loaduse = idex_memread_i & idex_rt_i≠0 & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i))
  - redirect = branch_taken_i | jump_i
- Priority: freeze > load-use > redirect. Exactly one action applies per cycle.
- Freeze (RUN with memstall, or MEMWAIT with ~mem_ready_i):
  - pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0
  - ifid_flush_o=0, idex_bubble_o=0
- Load-use (RUN, no memstall, loaduse):
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for that cycle
  - A concurrent redirect is ignored; it is re-evaluated next cycle.
- Redirect (RUN, no freeze, no loaduse):
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1
- Otherwise all enables are 1 and flush, bubble and freeze are 0.
- Transitions:
  - RUN→MEMWAIT on memstall.
  - MEMWAIT→RUN on mem_ready_i. In that cycle outputs follow the normal RUN rules, so a pending hazard is serviced immediately.
- Wait counter:
  - Cleared on entry to MEMWAIT, increments each MEMWAIT cycle.
  - When it reaches MEM_TIMEOUT−1 with ~mem_ready_i, mem_err_o sets next edge.
  - The state stays MEMWAIT. mem_err_o clears only on rst_i.
- Counters:
  - stall_cnt_o +1 per freeze or load-use cycle.
  - flush_cnt_o +1 per redirect cycle.
  - Both saturate at all-ones.

## Timing
- Reset values (registered effect after the edge with rst_i=1):
  - state=RUN; stall_cnt_o=0, flush_cnt_o=0, mem_err_o=0, wait counter 0.
- While rst_i=1, outputs are forced:
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, pipe_freeze_o=0, idex_bubble_o=1.
- Latency: decisions are zero-cycle (same-cycle combinational). Counter and error outputs lag their cause by one edge.
- A load-use bubble lasts exactly 1 cycle, because the bubble clears idex_memread_i on the next edge.
- A freeze lasts from the memstall cycle through the last ~mem_ready_i cycle. A response arriving in the request cycle causes no freeze.
- If rst_i is asserted mid-MEMWAIT, the state returns to RUN and mem_err_o is cleared.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum (RUN=1'b0, MEMWAIT=1'b1)
  - REG_ZERO=5'd0
  - default CNT_W
- Sub-module sat_counter (parameter W; inputs inc, clr; output q) is instantiated twice, for stall_cnt_o and flush_cnt_o.

## Test plan
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 → one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o=1. The same stimulus with idex_rt_i=0 → no stall.
- Load-use plus branch: both in the same cycle → bubble only, flush_cnt_o unchanged. branch_taken_i held into the next cycle → ifid_flush_o=1, flush_cnt_o=1.
- Memory wait: mem_req_i=1 with mem_ready_i low for 3 cycles then high → pipe_freeze_o=1 for 3 cycles, 0 on the ready cycle, stall_cnt_o=3, state back in RUN.
- Timeout: MEM_TIMEOUT=4, ready never asserted → mem_err_o=1 after the 4th MEMWAIT cycle, and it stays 1 after ready arrives. rst_i clears it.
- Saturation: CNT_W=4, 20 consecutive jump_i cycles → flush_cnt_o=15.
- Reset mid-wait: rst_i pulsed during MEMWAIT → next cycle state RUN, counters 0, outputs at their forced values during the reset cycle.
